// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Sequential load/store unit front end. Takes one access per
//               handshake, drives a req/gnt/rvalid data-memory port, aligns
//               byte lanes, builds write strobes and extends load data.
//               Accesses crossing a bus word are split into two beats when
//               LSU_MISALIGN_SPLIT_EN is defined; otherwise such accesses,
//               and any access not naturally aligned, fault without touching
//               memory.
// Macro       : LSU_MISALIGN_SPLIT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_sl_type_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_fault_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int c_NB    = XLEN / 8;
    localparam int c_OFS_W = $clog2(c_NB);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int c_BEATS = 2;
`else
    localparam int c_BEATS = 1;
`endif
    // Width of the lane-shifted strobe/data window covering every beat
    localparam int c_SW = c_BEATS * c_NB;
    localparam int c_SD = c_BEATS * XLEN;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_store;
    logic                r_uns;
    logic [c_OFS_W-1:0]  r_off;
    logic [3:0]          r_sz;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [c_NB-1:0]     r_mem_wstrb;
    logic [XLEN-1:0]     r_mem_wdata;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_rdata;
    logic                r_resp_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic                r_split;
    logic [XLEN-1:0]     r_beat0;
    logic [c_NB-1:0]     r_strb_hi;
    logic [XLEN-1:0]     r_wdata_hi;
`endif

    logic [c_OFS_W-1:0]  w_off;
    logic [3:0]          w_sz;
    logic [4:0]          w_end;
    logic                w_split;
    logic                w_illegal;
    logic                w_fault;
    logic [c_SW-1:0]     w_strb_full;
    logic [c_SD-1:0]     w_wdata_full;

    // Shift the byte stream down to the access offset, keep sz bytes and
    // sign- or zero-extend from the top kept byte.
    function automatic logic [XLEN-1:0] f_load_extend(
        input logic [c_SD-1:0]    stream,
        input logic [c_OFS_W-1:0] off,
        input logic [3:0]         sz,
        input logic               uns
    );
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] mask;
        logic            sign;
        data = XLEN'(stream >> (8 * off));
        for (int i = 0; i < c_NB; i++) begin
            mask[8*i +: 8] = (i < int'(sz)) ? 8'hFF : 8'h00;
        end
        case (sz)
            4'd1:    sign = data[7];
            4'd2:    sign = data[15];
            4'd4:    sign = data[31];
            default: sign = data[XLEN-1];
        endcase
        sign = sign & ~uns;
        return (data & mask) | (sign ? ~mask : '0);
    endfunction

    // Decode the incoming request: offset, size, split and legality
    always_comb begin
        w_off = req_addr_i[c_OFS_W-1:0];
        case (req_sl_type_i[1:0])
            2'b01:   w_sz = 4'd1;
            2'b10:   w_sz = 4'd2;
            2'b11:   w_sz = 4'd4;
            default: w_sz = 4'd8;
        endcase
        w_end     = 5'(w_off) + 5'(w_sz);
        w_split   = (w_end > 5'(c_NB));
        w_illegal = ((req_sl_type_i[1:0] == 2'b00) && (XLEN == 32)) ||
                    (req_sl_type_i[3] && req_sl_type_i[2]);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_fault   = w_illegal;
`else
        // Without split support, anything not naturally aligned faults
        w_fault   = w_illegal || w_split ||
                    ((4'(w_off) & (w_sz - 4'd1)) != 4'd0);
`endif
        w_strb_full  = c_SW'((32'd1 << w_sz) - 32'd1) << w_off;
        w_wdata_full = c_SD'(req_wdata_i) << (8 * w_off);
    end

    // Access sequencer with registered memory and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_store      <= 1'b0;
            r_uns        <= 1'b0;
            r_off        <= '0;
            r_sz         <= 4'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split      <= 1'b0;
            r_beat0      <= '0;
            r_strb_hi    <= '0;
            r_wdata_hi   <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_store      <= req_sl_type_i[3];
                        r_uns        <= req_sl_type_i[2];
                        r_off        <= w_off;
                        r_sz         <= w_sz;
                        r_resp_rdata <= '0;
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end else begin
                            r_state     <= S_REQ0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_sl_type_i[3];
                            r_mem_addr  <= {req_addr_i[ADDR_W-1:c_OFS_W], {c_OFS_W{1'b0}}};
                            // Loads carry no strobes and no write data
                            r_mem_wstrb <= req_sl_type_i[3] ? w_strb_full[c_NB-1:0] : '0;
                            r_mem_wdata <= req_sl_type_i[3] ? w_wdata_full[XLEN-1:0] : '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                            r_split     <= w_split;
                            r_strb_hi   <= req_sl_type_i[3] ? w_strb_full[c_SW-1:c_NB] : '0;
                            r_wdata_hi  <= req_sl_type_i[3] ? w_wdata_full[c_SD-1:XLEN] : '0;
`endif
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (r_split) begin
                            r_beat0     <= mem_rdata_i;
                            r_state     <= S_REQ1;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(c_NB);
                            r_mem_wstrb <= r_strb_hi;
                            r_mem_wdata <= r_wdata_hi;
                        end else
`endif
                        begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= r_store ? '0 :
                                            f_load_extend(c_SD'(mem_rdata_i), r_off, r_sz, r_uns);
                        end
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_REQ1: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid_i) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_store ? '0 :
                                        f_load_extend({mem_rdata_i, r_beat0}, r_off, r_sz, r_uns);
                    end
                end
`endif
                S_RESP: begin
                    // Response fields are only meaningful alongside the pulse
                    r_state      <= S_IDLE;
                    r_resp_rdata <= '0;
                    r_resp_fault <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wstrb_o  = r_mem_wstrb;
    assign mem_wdata_o  = r_mem_wdata;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_resp_rdata;
    assign resp_fault_o = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Self-checking bench for lsu_mem_ctrl (XLEN=32). Directed
//               vector table, hand-written corner sequences and randomized
//               accesses against a byte-level memory reference model.
//               Expectations follow LSU_MISALIGN_SPLIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = 4;
    localparam int BUDGET = 60;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3:0]        req_sl_type_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [XLEN-1:0]   req_wdata_i;
    logic              resp_valid_o;
    logic [XLEN-1:0]   resp_rdata_o;
    logic              resp_fault_o;
    logic              busy_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [NB-1:0]     mem_wstrb_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    lsu_mem_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_sl_type_i(req_sl_type_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_fault_o(resp_fault_o), .busy_o(busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory seen by the DUT (written through strobes) and reference memory
    logic [7:0] dut_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    // Per-access observations
    logic        got_valid, got_fault, after_valid, unstable;
    logic [31:0] got_rdata;
    int          got_beats, got_lat;
    logic [31:0] b_addr [2];
    logic [3:0]  b_strb [2];
    logic [31:0] b_wdata [2];
    logic        b_we [2];

    typedef struct packed {
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  lat;
        logic [1:0]  beats;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic        we;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] dut_word(input logic [31:0] a);
        return {dut_rd(a + 32'd3), dut_rd(a + 32'd2), dut_rd(a + 32'd1), dut_rd(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) dut_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one access and play the memory side with the given grant and
    // rvalid delays (same delays for every beat).
    task automatic run_access(input logic [3:0] typ, input logic [31:0] addr,
                              input logic [31:0] wd, input int gdly, input int rdly);
        int k, waitg, rcnt;
        bit pend, seen;
        logic [31:0] paddr, s_addr, s_wdata;
        logic [3:0]  s_strb;
        logic        s_we;
        got_valid = 0; got_fault = 0; got_rdata = '0; got_beats = 0; got_lat = 0;
        unstable = 0; after_valid = 0;
        paddr = '0; s_addr = '0; s_wdata = '0; s_strb = '0; s_we = 0;
        req_valid_i = 1'b1; req_sl_type_i = typ; req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        k = 1; waitg = 0; rcnt = 0; pend = 0; seen = 0;
        while (!got_valid && k <= BUDGET) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (resp_valid_o) begin
                got_valid = 1; got_rdata = resp_rdata_o; got_fault = resp_fault_o; got_lat = k;
            end else if (pend) begin
                if (rcnt >= rdly) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = dut_word(paddr); pend = 0;
                end else rcnt++;
            end else if (mem_req_o) begin
                if (!seen) begin
                    seen = 1; s_addr = mem_addr_o; s_strb = mem_wstrb_o;
                    s_wdata = mem_wdata_o; s_we = mem_we_o;
                end else if (mem_addr_o !== s_addr || mem_wstrb_o !== s_strb ||
                             mem_wdata_o !== s_wdata || mem_we_o !== s_we) begin
                    unstable = 1;
                end
                if (waitg >= gdly) begin
                    mem_gnt_i = 1'b1;
                    if (got_beats < 2) begin
                        b_addr[got_beats] = mem_addr_o; b_strb[got_beats] = mem_wstrb_o;
                        b_wdata[got_beats] = mem_wdata_o; b_we[got_beats] = mem_we_o;
                    end
                    got_beats++;
                    if (mem_we_o)
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb_o[i]) dut_mem[mem_addr_o + 32'(i)] = mem_wdata_o[8*i +: 8];
                    paddr = mem_addr_o; pend = 1; rcnt = 0; waitg = 0; seen = 0;
                end else waitg++;
            end
            if (!got_valid) begin
                @(posedge clk); #1;
                k++;
            end
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("resp_within_budget", got_valid, 1'b1);
        if (!got_valid) do_reset();
        else begin
            @(posedge clk); #1;
            after_valid = resp_valid_o;
        end
    endtask

    // Reference: byte-addressed view of the access rules
    task automatic model(input logic [3:0] typ, input logic [31:0] addr, input logic [31:0] wd,
                         output logic ef, output logic [31:0] er, output int eb);
        int sz, off;
        bit split;
        logic [31:0] v;
        case (typ[1:0])
            2'd1:    sz = 1;
            2'd2:    sz = 2;
            2'd3:    sz = 4;
            default: sz = 8;
        endcase
        off   = int'(addr[1:0]);
        split = (off + sz) > NB;
        ef = (typ[1:0] == 2'd0) || (typ[3] && typ[2]) ||
             (!SPLIT_EN && (split || (off % sz) != 0));
        er = '0; eb = 0;
        if (!ef) begin
            eb = split ? 2 : 1;
            if (typ[3]) begin
                for (int i = 0; i < sz; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_rd(addr + 32'(i));
                if (!typ[2] && v[8*sz-1])
                    for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
                er = v;
            end
        end
    endtask

    initial begin
        logic        ef, seen_resp;
        logic [31:0] er;
        int          eb, g, r;
        logic [3:0]  typ;
        logic [31:0] addr, wd;

        rst = 1'b1; req_valid_i = 0; req_sl_type_i = '0; req_addr_i = '0; req_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

        // typ, addr, wd, m0, m1, rdata, fault, lat, beats, a0, s0, d0, we, a1, s1, d1
        tbl[0]  = '{4'b0001, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 32'hFFFFFF80, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[1]  = '{4'b0110, 32'h1002, 32'h0, 32'h80FF1234, 32'h0, 32'h000080FF, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[2]  = '{4'b0010, 32'h1002, 32'h0, 32'h80FF1234, 32'h0, 32'hFFFF80FF, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[3]  = '{4'b1001, 32'h2001, 32'hAB, 32'h0, 32'h0, 32'h0, 1'b0, 4'd3, 2'd1, 32'h2000, 4'b0010, 32'h0000AB00, 1'b1, 32'h0, 4'h0, 32'h0};
        tbl[6]  = '{4'b0011, 32'h1000, 32'h0, 32'hDDCCBBAA, 32'h0, 32'hDDCCBBAA, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[7]  = '{4'b0000, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[8]  = '{4'b1101, 32'h1000, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[9]  = '{4'b0101, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 32'h00000080, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[12] = '{4'b1011, 32'h3000, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 1'b0, 4'd3, 2'd1, 32'h3000, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_SPLIT_EN
        tbl[4]  = '{4'b1011, 32'h1002, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, 4'd5, 2'd2, 32'h1000, 4'b1100, 32'h56780000, 1'b1, 32'h1004, 4'b0011, 32'h00001234};
        tbl[5]  = '{4'b0011, 32'h1001, 32'h0, 32'hDDCCBBAA, 32'h44332211, 32'h11DDCCBB, 1'b0, 4'd5, 2'd2, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h1004, 4'h0, 32'h0};
        tbl[10] = '{4'b0010, 32'h1001, 32'h0, 32'h80FF1234, 32'h0, 32'hFFFFFF12, 1'b0, 4'd3, 2'd1, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[11] = '{4'b1010, 32'h1003, 32'hBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 4'd5, 2'd2, 32'h1000, 4'b1000, 32'hEF000000, 1'b1, 32'h1004, 4'b0001, 32'h000000BE};
`else
        tbl[4]  = '{4'b1011, 32'h1002, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[5]  = '{4'b0011, 32'h1001, 32'h0, 32'hDDCCBBAA, 32'h44332211, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[10] = '{4'b0010, 32'h1001, 32'h0, 32'h80FF1234, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        tbl[11] = '{4'b1010, 32'h1003, 32'hBEEF, 32'h0, 32'h0, 32'h0, 1'b1, 4'd1, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
`endif

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.ready", req_ready_o, 1'b1);
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.mem_req", mem_req_o, 1'b0);
        chk("rst.outputs", {mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o}, '0);
        chk("rst.resp", {resp_valid_o, resp_fault_o, resp_rdata_o}, '0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            set_word({tbl[i].addr[31:2], 2'b00}, tbl[i].m0);
            set_word({tbl[i].addr[31:2], 2'b00} + 32'd4, tbl[i].m1);
            run_access(tbl[i].typ, tbl[i].addr, tbl[i].wd, 0, 0);
            chk($sformatf("vec%0d.fault", i), got_fault, tbl[i].fault);
            chk($sformatf("vec%0d.rdata", i), got_rdata, tbl[i].rdata);
            chk($sformatf("vec%0d.latency", i), got_lat, tbl[i].lat);
            chk($sformatf("vec%0d.beats", i), got_beats, tbl[i].beats);
            chk($sformatf("vec%0d.single_pulse", i), after_valid, 1'b0);
            if (tbl[i].beats >= 1 && got_beats >= 1) begin
                chk($sformatf("vec%0d.addr0", i), b_addr[0], tbl[i].a0);
                chk($sformatf("vec%0d.wstrb0", i), b_strb[0], tbl[i].s0);
                chk($sformatf("vec%0d.we0", i), b_we[0], tbl[i].we);
                if (tbl[i].we) chk($sformatf("vec%0d.wdata0", i), b_wdata[0], tbl[i].d0);
            end
            if (tbl[i].beats == 2 && got_beats == 2) begin
                chk($sformatf("vec%0d.addr1", i), b_addr[1], tbl[i].a1);
                chk($sformatf("vec%0d.wstrb1", i), b_strb[1], tbl[i].s1);
                if (tbl[i].we) chk($sformatf("vec%0d.wdata1", i), b_wdata[1], tbl[i].d1);
            end
        end

        // Grant withheld for 4 cycles: request must hold steady
        run_access(4'b1011, 32'h4000, 32'h0BADF00D, 4, 0);
        chk("gntwait.stable", unstable, 1'b0);
        chk("gntwait.latency", got_lat, 7);
        chk("gntwait.beats", got_beats, 1);
        chk("gntwait.wdata", b_wdata[0], 32'h0BADF00D);
        chk("gntwait.wstrb", b_strb[0], 4'hF);

        // Reset while waiting for rvalid; a late rvalid must be ignored
        req_valid_i = 1'b1; req_sl_type_i = 4'b0011; req_addr_i = 32'h1000; req_wdata_i = '0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("rstmid.req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        chk("rstmid.busy_wait0", busy_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.ready", req_ready_o, 1'b1);
        chk("rstmid.busy", busy_o, 1'b0);
        chk("rstmid.mem_req", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        seen_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid_o) seen_resp = 1'b1;
            @(posedge clk); #1;
        end
        chk("rstmid.late_rvalid_resp", seen_resp, 1'b0);
        chk("rstmid.idle_after", req_ready_o, 1'b1);

        // Request held through RESP is only accepted in the following IDLE
        req_valid_i = 1'b1; req_sl_type_i = 4'b0000; req_addr_i = 32'h1000;
        @(posedge clk); #1;
        chk("resp_hold.resp1", resp_valid_o, 1'b1);
        chk("resp_hold.ready_in_resp", req_ready_o, 1'b0);
        @(posedge clk); #1;
        chk("resp_hold.ready_idle", req_ready_o, 1'b1);
        chk("resp_hold.no_resp", resp_valid_o, 1'b0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("resp_hold.resp2", resp_valid_o, 1'b1);
        chk("resp_hold.fault2", resp_fault_o, 1'b1);
        @(posedge clk); #1;

        // Randomized accesses against the reference model
        dut_mem.delete();
        ref_mem.delete();
        for (int n = 0; n < 300; n++) begin
            typ  = 4'($urandom_range(0, 15));
            addr = 32'h100 + 32'($urandom_range(0, 31));
            wd   = $urandom;
            g    = $urandom_range(0, 2);
            r    = $urandom_range(0, 2);
            model(typ, addr, wd, ef, er, eb);
            run_access(typ, addr, wd, g, r);
            chk($sformatf("rnd%0d.fault t=%h a=%h", n, typ, addr), got_fault, ef);
            chk($sformatf("rnd%0d.rdata t=%h a=%h", n, typ, addr), got_rdata, er);
            chk($sformatf("rnd%0d.beats t=%h a=%h", n, typ, addr), got_beats, eb);
            chk($sformatf("rnd%0d.latency", n), got_lat, ef ? 1 : 1 + eb * (2 + g + r));
            chk($sformatf("rnd%0d.single_pulse", n), after_valid, 1'b0);
        end
        for (int a = 'h100; a < 'h128; a++) begin
            chk($sformatf("mem@%0h", a), dut_rd(32'(a)), ref_rd(32'(a)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised, sequential successor to the combinational load/store lane aligner.
- Accepts one load/store per handshake from the MEM stage and drives a request/grant/rvalid data-memory port.
- Aligns byte lanes, generates write strobes, and sign- or zero-extends load data.
- Splits accesses that cross a bus word into two aligned beats; supports XLEN 32 or 64 with one outstanding access.

Parameters:
- XLEN, 32, data width; legal values are 32 or 64. NB = XLEN/8 and OFS_W = log2(NB).
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid_i  input  1  access request.
- req_ready_o  output  1  block can accept; high only in IDLE.
- req_sl_type_i  input  4  access type:
  - [3] = 1 store, 0 load.
  - [2] = 1 unsigned load.
  - [1:0] size: 01 byte, 10 half, 11 word, 00 double (XLEN=64 only).
- req_addr_i  input  ADDR_W  byte address.
- req_wdata_i  input  XLEN  store data, LSB-justified.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_rdata_o  output  XLEN  extended load data; 0 for stores and faults.
- resp_fault_o  output  1  access faulted; valid with resp_valid_o.
- busy_o  output  1  high in any state other than IDLE.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  write request.
- mem_addr_o  output  ADDR_W  NB-aligned beat address.
- mem_wstrb_o  output  NB  byte-lane write enables.
- mem_wdata_o  output  XLEN  lane-shifted write data.
- mem_gnt_i  input  1  request accepted.
- mem_rvalid_i  input  1  beat completion; carries read data for loads and acknowledges stores.
- mem_rdata_i  input  XLEN  read data.

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register type/addr/wdata and compute off = addr[OFS_W-1:0] and sz = 1/2/4/8 bytes.
  - Illegal type (size 00 with XLEN=32, or store with [2]=1) -> RESP with fault, no memory access.
  - Otherwise -> REQ0.
- split = (off + sz > NB).
- REQ0:
  - mem_req_o=1, addr = {addr[ADDR_W-1:OFS_W], 0}.
  - wstrb = (sz-ones mask << off) truncated to NB; wdata = req_wdata << 8*off.
  - Outputs hold stable until mem_gnt_i, then -> WAIT0.
- WAIT0:
  - mem_req_o=0. On mem_rvalid_i, capture rdata into beat0 register.
  - -> REQ1 if split, else -> RESP.
- REQ1:
  - addr = beat0 addr + NB (wraps modulo 2^ADDR_W).
  - wstrb = remaining mask bits (mask >> (NB-off)); wdata = req_wdata >> 8*(NB-off).
  - On gnt -> WAIT1.
- WAIT1: on mem_rvalid_i, capture beat1 -> RESP.
- Load assembly:
  - Byte stream = {beat1, beat0} >> 8*off, truncated to sz bytes.
  - Sign-extend from the top byte when [2]=0, zero-extend when [2]=1.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then -> IDLE.
  - No backpressure on the response.
- mem_rvalid_i is never sampled in the same cycle as its own grant. It is ignored in IDLE, REQ0, REQ1 and RESP.
- Minimum latency, with gnt in the first request cycle and rvalid one cycle later, counting the accept cycle as T:
  - Aligned access: resp_valid_o at T+3.
  - Split access: resp_valid_o at T+5.
- Reset: all state -> IDLE; every output 0 except req_ready_o=1.
  - Reset mid-access drops mem_req_o at the next edge.
  - No response is produced for the aborted access.
  - A late mem_rvalid_i after reset is ignored.
- Simultaneous req_valid_i during RESP is not accepted (ready=0); it is accepted in the following IDLE cycle.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: split accesses behave as above via REQ1/WAIT1.
- Undefined:
  - REQ1/WAIT1 are not built.
  - Any access with split=1, or with off not a multiple of sz, goes IDLE -> RESP with resp_fault_o=1 and no memory request.
  - Aligned accesses are unchanged.

Test Plan:
- LB at 0x1003; rvalid data 0x80FF1234 -> resp_rdata_o=0xFFFFFF80; wstrb=0; resp_valid_o at T+3.
- LHU at 0x1002; data 0x80FF1234 -> 0x000080FF. LH at the same address and data -> 0xFFFF80FF.
- SB 0xAB at 0x2001 -> mem_addr_o=0x2000, wstrb=0010, wdata=0x0000AB00, mem_we_o=1, resp_rdata_o=0.
- SW 0x12345678 at 0x1002 (macro on):
  - Beat0: addr 0x1000, wstrb 1100, wdata 0x56780000.
  - Beat1: addr 0x1004, wstrb 0011, wdata 0x00001234.
  - Single resp_valid_o pulse.
- LW at 0x1001 with beat0=0xDDCCBBAA and beat1=0x44332211:
  - Macro on: 0x11DDCCBB at T+5.
  - Macro off: resp_fault_o=1, no mem_req_o.
- mem_gnt_i held low 4 cycles in REQ0 -> addr/wstrb/wdata stable throughout. Assert rst in WAIT0 -> IDLE next cycle, ready=1, and a late rvalid produces no resp_valid_o.
